cla16_pipe_adder: RTL
=====================

CLA16_PIPE_ADDER -- requirements
Module: cla16_pipe_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; SHALL be a multiple of GROUP.
REQ-002 Parameter: GROUP, default 4, bits per lookahead group.
REQ-003 Port: clk, input, 1, single clock; all state SHALL update on rising edge only.
REQ-004 Port: reset, input, 1, synchronous, active-high reset.
REQ-005 Port: in_valid, input, 1, operands valid.
REQ-006 Port: in_ready, output, 1, block accepts operands this cycle.
REQ-007 Port: a, input, WIDTH, operand A.
REQ-008 Port: b, input, WIDTH, operand B.
REQ-009 Port: sub, input, 1, 1 = compute a - b, 0 = compute a + b + cin.
REQ-010 Port: cin, input, 1, carry-in; ignored when sub=1.
REQ-011 Port: out_valid, output, 1, result valid.
REQ-012 Port: out_ready, input, 1, consumer accepts result.
REQ-013 Port: sum, output, WIDTH, result.
REQ-014 Port: cout, output, 1, carry out of MSB; for sub, 1 = no borrow.
REQ-015 Port: ovf, output, 1, signed two's-complement overflow.
REQ-016 Port: zero, output, 1, sum == 0.
REQ-017 Port: neg, output, 1, sum[WIDTH-1].

Function
REQ-018 A transfer SHALL occur on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-019 Stage 1 SHALL register a, b_eff = b XOR {WIDTH{sub}}, c_in = sub ? 1 : cin, plus per-group generate/propagate (G = group generate, P = AND of bitwise a|b_eff) for WIDTH/GROUP groups.
REQ-020 Stage 2 SHALL compute group carries c[k+1] = G[k] | (P[k] & c[k]), with c[0] = c_in, form each group's sum bits with the ripple of its own group carry, and register sum, cout, ovf, zero, neg.
REQ-021 ovf SHALL equal carry into MSB XOR carry out of MSB; zero and neg SHALL be derived from the registered sum value.
REQ-022 Latency SHALL be exactly 2 cycles from an accepted input to out_valid with no output stall; throughput SHALL be one result per cycle.
REQ-023 Stage 2 SHALL load when !out_valid || out_ready; stage 1 SHALL advance into stage 2 on that condition.
REQ-024 in_ready SHALL equal !s1_valid || stage-2 load condition (combinational from out_ready; no combinational path from in_valid to in_ready).
REQ-025 While out_valid && !out_ready, sum/cout/ovf/zero/neg SHALL remain stable and no accepted operand SHALL be lost or duplicated.
REQ-026 With both stages full and out_ready low, in_ready SHALL be 0; when out_ready rises, both stages SHALL advance in the same cycle and in_ready SHALL be 1.
REQ-027 Simultaneous output drain and input accept SHALL be supported in the same cycle.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-029 On reset, s1_valid and out_valid SHALL be 0; sum, cout, ovf, zero, neg SHALL be 0; in_ready SHALL be 1 in the first cycle after reset.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear after it.
REQ-031 Reset SHALL take priority over any concurrent handshake.

Structure
REQ-032 WIDTH, GROUP, and NGROUPS = WIDTH/GROUP SHALL be defined once in a shared package alu_pkg, for reuse by other ALU blocks.
REQ-033 The second-level carry chain SHALL be one combinational sub-module, lookahead_carry_unit (inputs P[], G[], c_in; outputs group carries and block carry-out).
REQ-034 The block SHALL contain only two pipeline register stages plus their valid bits; no FIFO.

Verification
REQ-035 a=0xFFFF, b=0x0001, sub=0, cin=0 -> two cycles later sum=0x0000, cout=1, zero=1, ovf=0, neg=0.
REQ-036 a=0x7FFF, b=0x0001, sub=0, cin=0 -> sum=0x8000, ovf=1, neg=1, cout=0.
REQ-037 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, neg=1, ovf=0 (cin ignored); a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-038 Stream of 8 back-to-back additions (i + 0x1000·i) with out_ready held low for cycles 3-5 -> in_ready=0 after two accepts, all 8 results delivered in order, no drop or duplicate, outputs stable while stalled.
REQ-039 Accept two operands, assert reset for 1 cycle before they drain -> out_valid=0 and all outputs 0 after reset, no stale result emitted, in_ready=1 the following cycle.
REQ-040 Random a, b, sub, cin (10k vectors, random out_ready) -> sum/cout/ovf match the reference model a + (sub ? ~b : b) + (sub ? 1 : cin).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU sizing constants used by the adder and by other ALU blocks.
package alu_pkg;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned GROUP   = 4;
   localparam int unsigned NGROUPS = WIDTH / GROUP;

endpackage

// File: rtl/lookahead_carry_unit.sv
// Second-level carry chain: turns per-group generate/propagate and the block
// carry-in into the carry entering each group plus the block carry-out.
module lookahead_carry_unit #(
   parameter int unsigned NGROUPS = alu_pkg::NGROUPS
) (
   input  logic [NGROUPS-1:0] i_p,
   input  logic [NGROUPS-1:0] i_g,
   input  logic               i_c_in,
   output logic [NGROUPS-1:0] o_c,
   output logic               o_c_out
);

   // c[k+1] = G[k] | (P[k] & c[k]), with c[0] = c_in
   always_comb begin
      logic w_carry;
      o_c     = '0;
      w_carry = i_c_in;
      for (int unsigned k = 0; k < NGROUPS; k++) begin
         o_c[k]  = w_carry;
         w_carry = i_g[k] | (i_p[k] & w_carry);
      end
      o_c_out = w_carry;
   end

endmodule

// File: rtl/cla16_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshaking. Stage 1 registers operands and group G/P; stage 2 resolves the
// group carries, forms the sum and registers the result with its flags.
// WIDTH must be a multiple of GROUP.
module cla16_pipe_adder #(
   parameter int unsigned WIDTH = alu_pkg::WIDTH,
   parameter int unsigned GROUP = alu_pkg::GROUP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned NGRP = WIDTH / GROUP;

   // Stage 1 state
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b_eff;
   logic             r_c_in;
   logic [NGRP-1:0]  r_g;
   logic [NGRP-1:0]  r_p;

   // Stage 2 state
   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;

   // Combinational nets
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c_in;
   logic [NGRP-1:0]  w_g;
   logic [NGRP-1:0]  w_p;
   logic [NGRP-1:0]  w_gc;
   logic             w_cout;
   logic [WIDTH-1:0] w_sum;
   logic             w_c_msb;
   logic             w_s2_load;
   logic             w_in_ready;

   // Stage 2 can take new data when empty or when its result is being consumed.
   assign w_s2_load  = !r_out_valid || out_ready;
   assign w_in_ready = !r_s1_valid || w_s2_load;

   // Operand conditioning and per-group generate/propagate
   always_comb begin
      logic w_gen;
      logic w_prop;
      w_b_eff = b ^ {WIDTH{sub}};
      w_c_in  = sub ? 1'b1 : cin;
      w_g     = '0;
      w_p     = '0;
      for (int unsigned k = 0; k < NGRP; k++) begin
         w_gen  = 1'b0;
         w_prop = 1'b1;
         for (int unsigned j = 0; j < GROUP; j++) begin
            w_gen  = (a[k*GROUP+j] & w_b_eff[k*GROUP+j])
                     | ((a[k*GROUP+j] | w_b_eff[k*GROUP+j]) & w_gen);
            w_prop = w_prop & (a[k*GROUP+j] | w_b_eff[k*GROUP+j]);
         end
         w_g[k] = w_gen;
         w_p[k] = w_prop;
      end
   end

   // Stage 1 register: captures operands on an input transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_a        <= '0;
         r_b_eff    <= '0;
         r_c_in     <= 1'b0;
         r_g        <= '0;
         r_p        <= '0;
      end else begin
         if (w_in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (in_valid && w_in_ready) begin
            r_a     <= a;
            r_b_eff <= w_b_eff;
            r_c_in  <= w_c_in;
            r_g     <= w_g;
            r_p     <= w_p;
         end
      end
   end

   lookahead_carry_unit #(
      .NGROUPS (NGRP)
   ) u_lcu (
      .i_p     (r_p),
      .i_g     (r_g),
      .i_c_in  (r_c_in),
      .o_c     (w_gc),
      .o_c_out (w_cout)
   );

   // Group sums: each group ripples its own bits from its lookahead carry
   always_comb begin
      logic w_carry;
      w_sum = '0;
      for (int unsigned k = 0; k < NGRP; k++) begin
         w_carry = w_gc[k];
         for (int unsigned j = 0; j < GROUP; j++) begin
            w_sum[k*GROUP+j] = r_a[k*GROUP+j] ^ r_b_eff[k*GROUP+j] ^ w_carry;
            w_carry = (r_a[k*GROUP+j] & r_b_eff[k*GROUP+j])
                      | ((r_a[k*GROUP+j] | r_b_eff[k*GROUP+j]) & w_carry);
         end
      end
      // Carry into the MSB recovered from its sum bit
      w_c_msb = w_sum[WIDTH-1] ^ r_a[WIDTH-1] ^ r_b_eff[WIDTH-1];
   end

   // Stage 2 register: result and flags, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_c_msb ^ w_cout;
            r_zero <= (w_sum == '0);
            r_neg  <= w_sum[WIDTH-1];
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;
   assign neg       = r_neg;

endmodule
